fpu_issue_ctrl: RTL

Issue controller between the integer core and the in_rvfpm floating-point unit. It accepts F-extension instructions from the core over a valid/ready handshake and decodes their operand and destination registers. It holds an instruction back until it has no RAW/WAW hazard against FP writes still in the pipeline, then drives the FPU enable/instruction/id/data inputs. It also tracks the ids of in-flight ops that return results to the core or memory, and checks them against the FPU's id_out.

---
 rtl/rvfpm_ctrl_pkg.sv | 89 ++++++++
 rtl/fpu_res_fifo.sv | 73 +++++++
 rtl/fpu_issue_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rvfpm_ctrl_pkg.sv
// Shared decode definitions for the in_rvfpm issue controller.
// Classifies F-extension instructions and extracts their FP register usage.
package rvfpm_ctrl_pkg;

    localparam logic [6:0] OpcLoad   = 7'b0000111;
    localparam logic [6:0] OpcStore  = 7'b0100111;
    localparam logic [6:0] OpcOpFp   = 7'b1010011;
    localparam logic [6:0] OpcFmadd  = 7'b1000011;
    localparam logic [6:0] OpcFmsub  = 7'b1000111;
    localparam logic [6:0] OpcFnmsub = 7'b1001011;
    localparam logic [6:0] OpcFnmadd = 7'b1001111;

    localparam logic [6:0] F7Cmp   = 7'b1010000;
    localparam logic [6:0] F7CvtWS = 7'b1100000;
    localparam logic [6:0] F7MvXW  = 7'b1110000;
    localparam logic [6:0] F7CvtSW = 7'b1101000;
    localparam logic [6:0] F7MvWX  = 7'b1111000;

    typedef enum logic [2:0] {
        OpLoad, OpStore, OpFpToFp, OpFpToX, OpXToFp, OpFma, OpIllegal
    } op_class_e;

    typedef enum logic {ResX, ResMem} res_kind_e;

    typedef struct packed {
        op_class_e op_class;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       uses_rs3;
        logic       writes_frd;
        logic       pushes_fifo;
        res_kind_e  res_kind;
    } decoded_t;

    function automatic decoded_t decode_instr(input logic [31:0] instr);
        decoded_t   d;
        logic [6:0] f7;
        d          = '0;
        d.op_class = OpIllegal;
        d.res_kind = ResX;
        d.rd       = instr[11:7];
        d.rs1      = instr[19:15];
        d.rs2      = instr[24:20];
        d.rs3      = instr[31:27];
        f7         = instr[31:25];
        case (instr[6:0])
            OpcLoad: begin
                d.op_class   = OpLoad;
                d.writes_frd = 1'b1;
            end
            OpcStore: begin
                d.op_class    = OpStore;
                d.uses_rs2    = 1'b1;
                d.pushes_fifo = 1'b1;
                d.res_kind    = ResMem;
            end
            OpcOpFp: begin
                if (f7 == F7Cmp || f7 == F7CvtWS || f7 == F7MvXW) begin
                    d.op_class    = OpFpToX;
                    d.uses_rs1    = 1'b1;
                    d.uses_rs2    = (f7 == F7Cmp);
                    d.pushes_fifo = 1'b1;
                end else if (f7 == F7CvtSW || f7 == F7MvWX) begin
                    d.op_class   = OpXToFp;
                    d.writes_frd = 1'b1;
                end else begin
                    d.op_class   = OpFpToFp;
                    d.uses_rs1   = 1'b1;
                    d.uses_rs2   = 1'b1;
                    d.writes_frd = 1'b1;
                end
            end
            OpcFmadd, OpcFmsub, OpcFnmsub, OpcFnmadd: begin
                d.op_class   = OpFma;
                d.uses_rs1   = 1'b1;
                d.uses_rs2   = 1'b1;
                d.uses_rs3   = 1'b1;
                d.writes_frd = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fpu_res_fifo.sv
// Tracks id and destination kind of in-flight ops that return results to the core or memory.
// A simultaneous push and pop is allowed even when full.
module fpu_res_fifo
    import rvfpm_ctrl_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic [IdWidth-1:0] push_id_i,
    input  res_kind_e          push_kind_i,
    input  logic               pop_i,
    output logic [IdWidth-1:0] head_id_o,
    output res_kind_e          head_kind_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [IdWidth-1:0] id_q   [Depth];
    res_kind_e          kind_q [Depth];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               do_push, do_pop;

    assign full_o      = (count_q == CntW'(Depth));
    assign empty_o     = (count_q == '0);
    assign head_id_o   = id_q[rd_ptr_q];
    assign head_kind_o = kind_q[rd_ptr_q];
    assign do_push     = push_i && (!full_o || pop_i);
    assign do_pop      = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            id_q[wr_ptr_q]   <= push_id_i;
            kind_q[wr_ptr_q] <= push_kind_i;
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller in front of the in_rvfpm FPU: hazard-checks F-extension ops against
// pending FP register writes, registers them into the FPU and checks returning result ids.
module fpu_issue_ctrl
    import rvfpm_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS        = 32,
    parameter int unsigned PIPELINE_STAGES = 4,
    parameter int unsigned XLEN            = 32,
    parameter int unsigned FLEN            = 32,
    parameter int unsigned X_ID_WIDTH      = 4,
    parameter int unsigned RES_FIFO_DEPTH  = 4
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_instr,
    input  logic [X_ID_WIDTH-1:0] req_id,
    input  logic [XLEN-1:0]       req_xdata,
    input  logic [FLEN-1:0]       req_memdata,
    output logic                  fpu_enable,
    output logic [31:0]           fpu_instruction,
    output logic [X_ID_WIDTH-1:0] fpu_id,
    output logic [XLEN-1:0]       fpu_data_fromXreg,
    output logic [FLEN-1:0]       fpu_data_fromMem,
    input  logic [X_ID_WIDTH-1:0] fpu_id_out,
    input  logic                  fpu_toXreg_valid,
    input  logic                  fpu_toMem_valid,
    output logic                  stall,
    output logic                  illegal_op,
    output logic                  id_err,
    output logic                  busy
);
    localparam int unsigned    SbW    = $clog2(PIPELINE_STAGES + 2);
    localparam logic [SbW-1:0] SbInit = SbW'(PIPELINE_STAGES + 1);

    decoded_t              dec;
    logic                  hazard, accept, push, pop, kind_err;
    logic                  fifo_full, fifo_empty;
    logic [X_ID_WIDTH-1:0] head_id;
    res_kind_e             head_kind;

    logic [SbW-1:0]        sb_q [NUM_REGS];
    logic [SbW-1:0]        sb_d [NUM_REGS];
    logic                  fpu_enable_q, fpu_enable_d;
    logic [31:0]           fpu_instruction_q, fpu_instruction_d;
    logic [X_ID_WIDTH-1:0] fpu_id_q, fpu_id_d;
    logic [XLEN-1:0]       fpu_xdata_q, fpu_xdata_d;
    logic [FLEN-1:0]       fpu_memdata_q, fpu_memdata_d;
    logic                  illegal_op_q, illegal_op_d;
    logic                  id_err_q, id_err_d;

    assign dec    = decode_instr(req_instr);
    assign hazard = (dec.uses_rs1 && sb_q[dec.rs1] != '0) ||
                    (dec.uses_rs2 && sb_q[dec.rs2] != '0) ||
                    (dec.uses_rs3 && sb_q[dec.rs3] != '0) ||
                    (dec.writes_frd && sb_q[dec.rd] != '0);
    assign pop    = fpu_toXreg_valid || fpu_toMem_valid;

    // A pop in the same cycle frees the slot, so a full FIFO does not block acceptance then.
    assign req_ready = !hazard && !(fifo_full && dec.pushes_fifo && !pop);
    assign accept    = req_valid && req_ready;
    assign push      = accept && dec.pushes_fifo;
    assign stall     = req_valid && !req_ready;
    assign kind_err  = (head_kind == ResX) ? !fpu_toXreg_valid : !fpu_toMem_valid;

    fpu_res_fifo #(
        .Depth   (RES_FIFO_DEPTH),
        .IdWidth (X_ID_WIDTH)
    ) u_res_fifo (
        .clk_i       (ck),
        .rst_ni      (rst),
        .push_i      (push),
        .push_id_i   (req_id),
        .push_kind_i (dec.res_kind),
        .pop_i       (pop),
        .head_id_o   (head_id),
        .head_kind_o (head_kind),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            sb_d[i] = (sb_q[i] != '0) ? sb_q[i] - SbW'(1) : sb_q[i];
        end
        if (accept && dec.writes_frd) begin
            sb_d[dec.rd] = SbInit;
        end

        fpu_enable_d      = accept;
        fpu_instruction_d = accept ? req_instr : '0;
        fpu_id_d          = accept ? req_id : '0;
        fpu_xdata_d       = accept ? req_xdata : '0;
        fpu_memdata_d     = accept ? req_memdata : '0;
        illegal_op_d      = accept && (dec.op_class == OpIllegal);

        id_err_d = id_err_q;
        if (pop && (fifo_empty || head_id != fpu_id_out || kind_err)) begin
            id_err_d = 1'b1;
        end

        busy = !fifo_empty;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sb_q[i] != '0) begin
                busy = 1'b1;
            end
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                sb_q[i] <= '0;
            end
            fpu_enable_q      <= 1'b0;
            fpu_instruction_q <= '0;
            fpu_id_q          <= '0;
            fpu_xdata_q       <= '0;
            fpu_memdata_q     <= '0;
            illegal_op_q      <= 1'b0;
            id_err_q          <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                sb_q[i] <= sb_d[i];
            end
            fpu_enable_q      <= fpu_enable_d;
            fpu_instruction_q <= fpu_instruction_d;
            fpu_id_q          <= fpu_id_d;
            fpu_xdata_q       <= fpu_xdata_d;
            fpu_memdata_q     <= fpu_memdata_d;
            illegal_op_q      <= illegal_op_d;
            id_err_q          <= id_err_d;
        end
    end

    assign fpu_enable        = fpu_enable_q;
    assign fpu_instruction   = fpu_instruction_q;
    assign fpu_id            = fpu_id_q;
    assign fpu_data_fromXreg = fpu_xdata_q;
    assign fpu_data_fromMem  = fpu_memdata_q;
    assign illegal_op        = illegal_op_q;
    assign id_err            = id_err_q;

endmodule
